// File: rtl/ro_cache_ctrl_regs_pkg.sv
// Shared types, register map and flush FSM encoding
// for the read-only cache control registers.
package ro_cache_ctrl_regs_pkg;

  localparam int unsigned MaxAddrRules  = 16;
  localparam int unsigned CtrlAddrWidth = 32;

  localparam int unsigned RegEnable   = 'h00;
  localparam int unsigned RegFlush    = 'h04;
  localparam int unsigned RegStatus   = 'h08;
  localparam int unsigned RegRuleBase = 'h10;
  localparam int unsigned RegRuleStep = 'h08;

  localparam logic [0:0] FlushIdle   = 1'b0;
  localparam logic [0:0] FlushActive = 1'b1;

  typedef struct packed {
    logic                                      enable;
    logic [MaxAddrRules-1:0][CtrlAddrWidth-1:0] rule_start;
    logic [MaxAddrRules-1:0][CtrlAddrWidth-1:0] rule_end;
  } ro_cache_ctrl_t;

endpackage

// File: rtl/ro_cache_flush_tracker.sv
// Per-cache flush valid/ready bookkeeping with busy and
// sticky done status.
module ro_cache_flush_tracker
  import ro_cache_ctrl_regs_pkg::*;
#(
  parameter int unsigned NumCaches = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 done_clr_i,
  input  logic [NumCaches-1:0] flush_ready_i,
  output logic [NumCaches-1:0] flush_valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  logic [0:0]           state_q, state_d;
  logic [NumCaches-1:0] valid_q, valid_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = done_q & ~done_clr_i;
    unique case (state_q)
      FlushIdle: begin
        if (start_i) begin
          state_d = FlushActive;
          valid_d = '1;
        end
      end
      FlushActive: begin
        valid_d = valid_q & ~flush_ready_i;
        // set wins over a same-cycle clear
        if (valid_d == '0) begin
          state_d = FlushIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = FlushIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FlushIdle;
      valid_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign flush_valid_o = valid_q;
  assign busy_o        = (state_q == FlushActive);
  assign done_o        = done_q;

endmodule

// File: rtl/ro_cache_ctrl_regs.sv
// Control registers for the RO caches: enable, address
// rules and a tracked multi-cache flush.
module ro_cache_ctrl_regs
  import ro_cache_ctrl_regs_pkg::*;
#(
  parameter int unsigned NumAddrRules = 4,
  parameter int unsigned NumCaches    = 1,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegAddrWidth = $clog2(16 + 8 * NumAddrRules)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic                                  req_write_i,
  input  logic [RegAddrWidth-1:0]               req_addr_i,
  input  logic [DataWidth-1:0]                  req_wdata_i,
  input  logic [DataWidth/8-1:0]                req_strb_i,
  output logic                                  resp_valid_o,
  input  logic                                  resp_ready_i,
  output logic [DataWidth-1:0]                  resp_rdata_o,
  output logic                                  resp_error_o,
  output logic                                  enable_o,
  output logic [NumAddrRules-1:0][AddrWidth-1:0] rule_start_o,
  output logic [NumAddrRules-1:0][AddrWidth-1:0] rule_end_o,
  output logic [NumAddrRules-1:0]               rule_valid_o,
  output logic [NumCaches-1:0]                  flush_valid_o,
  input  logic [NumCaches-1:0]                  flush_ready_i,
  output logic                                  flush_busy_o
);

  localparam int unsigned WordW = RegAddrWidth - 2;
  localparam int unsigned StrbW = DataWidth / 8;

  logic                                   enable_q, enable_d;
  logic [NumAddrRules-1:0][AddrWidth-1:0] start_q, start_d;
  logic [NumAddrRules-1:0][AddrWidth-1:0] end_q, end_d;
  logic                                   rvalid_q, rvalid_d;
  logic                                   rerr_q, rerr_d;
  logic [DataWidth-1:0]                   rdata_q, rdata_d;

  logic [WordW-1:0]        word;
  logic                    aligned, busy, done, req_fire;
  logic                    sel_en, sel_flush, sel_status, sel_rule;
  logic [NumAddrRules-1:0] sel_start, sel_end;
  logic                    acc_err, wr_ok, flush_start, done_clr;
  logic [DataWidth-1:0]    rd_val;

  function automatic logic [DataWidth-1:0] merge(
    input logic [DataWidth-1:0] old,
    input logic [DataWidth-1:0] nv,
    input logic [StrbW-1:0]     strb
  );
    logic [DataWidth-1:0] r;
    r = old;
    for (int b = 0; b < int'(StrbW); b++) begin
      if (strb[b]) r[8*b +: 8] = nv[8*b +: 8];
    end
    return r;
  endfunction

  assign req_fire = req_valid_i & req_ready_o;
  assign word     = req_addr_i[RegAddrWidth-1:2];
  assign aligned  = (req_addr_i[1:0] == 2'b00);

  always_comb begin
    sel_en     = aligned && word == WordW'(RegEnable / 4);
    sel_flush  = aligned && word == WordW'(RegFlush / 4);
    sel_status = aligned && word == WordW'(RegStatus / 4);
    for (int i = 0; i < int'(NumAddrRules); i++) begin
      sel_start[i] = aligned &&
        word == WordW'((RegRuleBase + RegRuleStep * i) / 4);
      sel_end[i]   = aligned &&
        word == WordW'((RegRuleBase + RegRuleStep * i) / 4 + 1);
    end
    sel_rule = |{sel_start, sel_end};
    // config is frozen while caches are being flushed
    acc_err = ~(sel_en | sel_flush | sel_status | sel_rule)
            | (req_write_i & busy & (sel_en | sel_rule));

    rd_val = '0;
    unique case (1'b1)
      sel_en:     rd_val[0] = enable_q;
      sel_flush:  rd_val[0] = busy;
      sel_status: rd_val[1:0] = {done, busy};
      default:    rd_val = '0;
    endcase
    for (int i = 0; i < int'(NumAddrRules); i++) begin
      if (sel_start[i]) rd_val = DataWidth'(start_q[i]);
      if (sel_end[i])   rd_val = DataWidth'(end_q[i]);
    end

    wr_ok       = req_fire & req_write_i & ~acc_err;
    flush_start = wr_ok & sel_flush & req_strb_i[0] & req_wdata_i[0];
    done_clr    = wr_ok & sel_status & req_strb_i[0] & req_wdata_i[1];

    enable_d = enable_q;
    start_d  = start_q;
    end_d    = end_q;
    if (wr_ok && sel_en && req_strb_i[0]) enable_d = req_wdata_i[0];
    for (int i = 0; i < int'(NumAddrRules); i++) begin
      if (wr_ok && sel_start[i])
        start_d[i] = AddrWidth'(merge(DataWidth'(start_q[i]),
                                      req_wdata_i, req_strb_i));
      if (wr_ok && sel_end[i])
        end_d[i] = AddrWidth'(merge(DataWidth'(end_q[i]),
                                    req_wdata_i, req_strb_i));
    end

    rvalid_d = rvalid_q;
    rerr_d   = rerr_q;
    rdata_d  = rdata_q;
    if (rvalid_q && resp_ready_i) begin
      rvalid_d = 1'b0;
      rerr_d   = 1'b0;
      rdata_d  = '0;
    end
    if (req_fire) begin
      rvalid_d = 1'b1;
      rerr_d   = acc_err;
      rdata_d  = (req_write_i | acc_err) ? '0 : rd_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      enable_q <= enable_d;
      start_q  <= start_d;
      end_q    <= end_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  ro_cache_flush_tracker #(
    .NumCaches(NumCaches)
  ) u_flush (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (flush_start),
    .done_clr_i   (done_clr),
    .flush_ready_i(flush_ready_i),
    .flush_valid_o(flush_valid_o),
    .busy_o       (busy),
    .done_o       (done)
  );

  for (genvar i = 0; i < int'(NumAddrRules); i++) begin : g_rule
    assign rule_valid_o[i] = end_q[i] > start_q[i];
  end

  assign req_ready_o  = ~rvalid_q;
  assign resp_valid_o = rvalid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_error_o = rerr_q;
  assign enable_o     = enable_q;
  assign rule_start_o = start_q;
  assign rule_end_o   = end_q;
  assign flush_busy_o = busy;

endmodule

// File: tb/tb_ro_cache_ctrl_regs.sv
// Bench for ro_cache_ctrl_regs: vector table, flush,
// stall and reset sequences with a response scoreboard.
module tb_ro_cache_ctrl_regs;

  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int RAW = 6;

  logic                   clk;
  logic                   rst;
  logic                   req_valid, req_ready, req_write;
  logic [RAW-1:0]         req_addr;
  logic [DW-1:0]          req_wdata;
  logic [DW/8-1:0]        req_strb;
  logic                   resp_valid, resp_ready, resp_error;
  logic [DW-1:0]          resp_rdata;
  logic                   enable;
  logic [NR-1:0][AW-1:0]  rule_start, rule_end;
  logic [NR-1:0]          rule_valid;
  logic [NC-1:0]          flush_valid, flush_ready;
  logic                   busy;

  ro_cache_ctrl_regs #(
    .NumAddrRules(NR),
    .NumCaches   (NC),
    .AddrWidth   (AW),
    .DataWidth   (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_strb_i   (req_strb),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_error_o (resp_error),
    .enable_o     (enable),
    .rule_start_o (rule_start),
    .rule_end_o   (rule_end),
    .rule_valid_o (rule_valid),
    .flush_valid_o(flush_valid),
    .flush_ready_i(flush_ready),
    .flush_busy_o (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        er;
    logic [3:0]  rv;
    logic        en;
  } exp_t;

  typedef struct packed {
    logic        w;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  rv;
    logic        en;
  } vec_t;

  exp_t  exp_q[$];
  string nm_q[$];
  vec_t  vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic w, input logic [5:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] rd, input logic er,
                              input logic [3:0] rv, input logic en);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s;
    v.rd = rd; v.er = er; v.rv = rv; v.en = en;
    return v;
  endfunction

  task automatic send(input logic w, input logic [5:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("req_ready timeout", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic collect();
    int    n;
    exp_t  e;
    string nm;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    chk({nm, " resp_valid"}, 32'(resp_valid), 1);
    chk({nm, " resp_error"}, 32'(resp_error), 32'(e.er));
    chk({nm, " rdata"}, resp_rdata, e.rd);
    chk({nm, " rule_valid"}, 32'(rule_valid), 32'(e.rv));
    chk({nm, " enable"}, 32'(enable), 32'(e.en));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic xact(input logic w, input logic [5:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] rd, input logic er,
                      input logic [3:0] rv, input logic en,
                      input string nm);
    exp_t e;
    e.rd = rd; e.er = er; e.rv = rv; e.en = en;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    send(w, a, d, s);
    collect();
  endtask

  task automatic ack(input logic [3:0] r, input logic [3:0] ev,
                     input logic eb, input string nm);
    @(negedge clk);
    flush_ready = r;
    @(posedge clk);
    #1;
    flush_ready = '0;
    chk({nm, " flush_valid"}, 32'(flush_valid), 32'(ev));
    chk({nm, " busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_strb    = '0;
    resp_ready  = 1'b0;
    flush_ready = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset req_ready", 32'(req_ready), 1);
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset rule_valid", 32'(rule_valid), 0);
    chk("reset flush_valid", 32'(flush_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset enable", 32'(enable), 0);

    vecs.push_back(mk(0, 6'h00, 0, 4'h0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 6'h04, 0, 4'h0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 6'h08, 0, 4'h0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 6'h10, 0, 4'h0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 6'h2C, 0, 4'h0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 6'h0C, 0, 4'h0, 0, 1, 4'b0000, 0));
    vecs.push_back(mk(1, 6'h11, 32'hFFFF_FFFF, 4'hF, 0, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 6'h10, 0, 4'h0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 6'h18, 32'h8000_0000, 4'hF, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 6'h1C, 32'h8000_1000, 4'hF, 0, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 6'h18, 0, 4'h0, 32'h8000_0000, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 6'h1C, 0, 4'h0, 32'h8000_1000, 0, 4'b0010, 0));
    vecs.push_back(mk(1, 6'h00, 1, 4'h0, 0, 0, 4'b0010, 0));
    vecs.push_back(mk(1, 6'h00, 1, 4'h1, 0, 0, 4'b0010, 1));
    vecs.push_back(mk(0, 6'h00, 0, 4'h0, 1, 0, 4'b0010, 1));
    vecs.push_back(mk(1, 6'h30, 1, 4'hF, 0, 1, 4'b0010, 1));
    vecs.push_back(mk(1, 6'h14, 1, 4'hF, 0, 0, 4'b0011, 1));
    vecs.push_back(mk(1, 6'h10, 1, 4'h1, 0, 0, 4'b0010, 1));
    vecs.push_back(mk(1, 6'h1C, 32'h7FFF_0000, 4'hC, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 6'h1C, 0, 4'h0, 32'h7FFF_1000, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 6'h2D, 0, 4'h0, 0, 1, 4'b0000, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      xact(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s,
           vecs[i].rd, vecs[i].er, vecs[i].rv, vecs[i].en,
           $sformatf("vec%0d", i));
    end
    chk("rule_start_o[1]", rule_start[1], 32'h8000_0000);
    chk("rule_end_o[1]", rule_end[1], 32'h7FFF_1000);

    xact(1, 6'h04, 1, 4'h1, 0, 0, 4'b0000, 1, "flush start");
    chk("flush start valid", 32'(flush_valid), 32'hF);
    chk("flush start busy", 32'(busy), 1);
    xact(1, 6'h00, 0, 4'h1, 0, 1, 4'b0000, 1, "enable while busy");
    xact(1, 6'h20, 5, 4'hF, 0, 1, 4'b0000, 1, "start2 while busy");
    xact(0, 6'h08, 0, 4'h0, 1, 0, 4'b0000, 1, "status busy");
    ack(4'b0100, 4'b1011, 1, "ack c2");
    xact(1, 6'h04, 1, 4'h1, 0, 0, 4'b0000, 1, "flush coalesce");
    chk("coalesce flush_valid", 32'(flush_valid), 32'b1011);
    ack(4'b0100, 4'b1011, 1, "re-ack c2");
    ack(4'b0001, 4'b1010, 1, "ack c0");
    ack(4'b1000, 4'b0010, 1, "ack c3");
    ack(4'b0010, 4'b0000, 0, "ack c1");
    xact(0, 6'h08, 0, 4'h0, 2, 0, 4'b0000, 1, "status done");
    xact(0, 6'h04, 0, 4'h0, 0, 0, 4'b0000, 1, "flush idle");
    xact(0, 6'h20, 0, 4'h0, 0, 0, 4'b0000, 1, "start2 kept");
    xact(1, 6'h08, 2, 4'h1, 0, 0, 4'b0000, 1, "status w1c");
    xact(0, 6'h08, 0, 4'h0, 0, 0, 4'b0000, 1, "status cleared");
    chk("no extra round", 32'(flush_valid), 0);

    begin
      exp_t e;
      e.rd = 32'h8000_0000; e.er = 1'b0; e.rv = 4'b0000; e.en = 1'b1;
      exp_q.push_back(e);
      nm_q.push_back("stalled read");
      send(0, 6'h18, 0, 4'h0);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("stall%0d req_ready", k), 32'(req_ready), 0);
        chk($sformatf("stall%0d rdata", k), resp_rdata, 32'h8000_0000);
        @(posedge clk);
        #1;
      end
      collect();
    end

    xact(1, 6'h04, 1, 4'h1, 0, 0, 4'b0000, 1, "flush again");
    send(0, 6'h00, 0, 4'h0);
    chk("pre-reset resp_valid", 32'(resp_valid), 1);
    chk("pre-reset busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst resp_valid", 32'(resp_valid), 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst resp_error", 32'(resp_error), 0);
    chk("rst req_ready", 32'(req_ready), 1);
    chk("rst enable", 32'(enable), 0);
    chk("rst rule_start1", rule_start[1], 0);
    chk("rst flush_valid", 32'(flush_valid), 0);
    chk("rst busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    xact(0, 6'h08, 0, 4'h0, 0, 0, 4'b0000, 0, "status after rst");
    xact(0, 6'h18, 0, 4'h0, 0, 0, 4'b0000, 0, "start1 after rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ro_cache_ctrl_regs.md
# ro_cache_ctrl_regs

Parametrised control-register block for the read-only caches: holds the global enable and a configurable number of cacheable address rules, and drives a multi-channel flush handshake to every cache instance. It sits between the system control-register bus and the per-group RO caches. It generalises the fixed four-rule, single-flush control struct to N rules, M caches, rule validation and a tracked flush.

## Interface
- NumAddrRules, 4: number of [start, end) cacheable windows, 1..16
- NumCaches, 1: number of RO cache instances (one per group) receiving flush
- AddrWidth, 32: width of rule addresses
- DataWidth, 32: register bus data width; must equal AddrWidth
- RegAddrWidth, derived: $clog2(16 + 8*NumAddrRules)

- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous active-high
- req_valid_i  in  1  register request valid
- req_ready_o  out  1  request accepted this cycle when high with valid
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  RegAddrWidth  byte address, word aligned
- req_wdata_i  in  DataWidth  write data
- req_strb_i  in  DataWidth/8  byte enables for writes
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_rdata_o  out  DataWidth  read data, 0 on writes/errors
- resp_error_o  out  1  access error
- enable_o  out  1  global cache enable
- rule_start_o  out  NumAddrRules x AddrWidth  rule start addresses
- rule_end_o  out  NumAddrRules x AddrWidth  rule end addresses (exclusive)
- rule_valid_o  out  NumAddrRules  rule i valid iff end_i > start_i (unsigned)
- flush_valid_o  out  NumCaches  per-cache flush request
- flush_ready_i  in  NumCaches  per-cache flush acknowledge
- flush_busy_o  out  1  any flush outstanding

## Operation
- Register map (byte offsets): 0x00 ENABLE (bit 0); 0x04 FLUSH (write bit 0 = 1 starts flush; read returns busy); 0x08 STATUS (bit 0 busy, bit 1 done-sticky, write-1-to-clear); 0x10+8i START_i; 0x14+8i END_i.
- Unmapped or unaligned address: resp_error_o = 1, no state change.
- Writes apply byte-wise per req_strb_i; strb = 0 is a legal no-op.
- rule_valid_o is combinational from the stored registers.
- Flush FSM: IDLE, FLUSH.
  - IDLE -> FLUSH on accepted FLUSH write with bit 0 = 1: all flush_valid_o bits set.
  - In FLUSH each flush_valid_o[c] clears on the cycle after flush_valid_o[c] && flush_ready_i[c]; others stay high.
  - FLUSH -> IDLE when all bits are clear; done-sticky sets the same edge.
- FLUSH write while busy: coalesced, no new round, no error.
- Writes to ENABLE/START/END while busy: resp_error_o = 1, registers unchanged. Reads are always allowed.
- Reset values: enable 0, all start/end 0 (all rules invalid), flush_valid_o 0, busy 0, done 0, resp_valid_o 0, resp_rdata_o 0, resp_error_o 0.

## Timing
- Single outstanding transaction: req_ready_o = ~resp_valid_o.
- Accepted request at edge t: resp_valid_o high from t+1, held with stable data until resp_valid_o && resp_ready_i.
- Register updates and flush start become visible on outputs at t+1, the same cycle as the response.
- flush_busy_o rises at t+1 and falls one cycle after the last acknowledge.
- Reset asserted mid-flush or mid-response drops all outputs to reset values on the next edge. No completion is reported.

## Structure
- In the shared package: ro_cache_ctrl_t, generalised to parameterised rule count; register offset constants; flush FSM state enum.
- One sub-module, ro_cache_flush_tracker: per-channel valid/ready bookkeeping and the busy/done logic.
- The register decode lives in the top module.

## Test plan
- Reset, read all registers -> 0; rule_valid_o = 0; req_ready_o = 1.
- Write START_1 = 0x8000_0000, END_1 = 0x8000_1000 -> rule_valid_o = 0b0010. Then write END_1 = 0x7FFF_0000 -> bit 1 clears.
- NumCaches = 4, write FLUSH = 1, ack caches 2, 0, 3, 1 on separate cycles -> the matching flush_valid_o bits clear individually; busy falls one cycle after cache 1 ack; STATUS reads 0b10.
- During flush, write ENABLE = 1 -> resp_error_o = 1, enable_o stays 0. A second FLUSH write -> no error, no extra round.
- Read 0x0C and write with req_addr_i = 0x11 -> both return resp_error_o = 1.
- Hold resp_ready_i = 0 for 5 cycles -> req_ready_o = 0 and response stable throughout. Then assert rst_i mid-flush -> all outputs return to reset values next edge.
